// File: rtl/noc_pkg.sv
// noc_pkg: flit types, port encodings and FSM states shared by the router input port.
package noc_pkg;
  typedef enum logic [1:0] {BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, SINGLE = 2'b11} flit_type_e;
  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_e;
  localparam int P_L = 0;
  localparam int P_N = 1;
  localparam int P_E = 2;
  localparam int P_S = 3;
  localparam int P_W = 4;
  localparam logic [4:0] PORT_L = 5'b00001;
  localparam logic [4:0] PORT_N = 5'b00010;
  localparam logic [4:0] PORT_E = 5'b00100;
  localparam logic [4:0] PORT_S = 5'b01000;
  localparam logic [4:0] PORT_W = 5'b10000;
  localparam int FLIT_W_DEF = 34;
  localparam int COORD_W_DEF = 4;
endpackage

// File: rtl/xy_route.sv
// xy_route: dimension-ordered route, X resolved before Y, one-hot output port.
module xy_route
  import noc_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic [7:0] dest,
  input  logic [7:0] my_addr,
  output logic [4:0] port
);
  logic [COORD_W-1:0] dx, dy, mx, my;
  assign {dx, dy} = dest;
  assign {mx, my} = my_addr;
  always_comb begin
    port = dx > mx ? PORT_E :
           dx < mx ? PORT_W :
           dy > my ? PORT_N :
           dy < my ? PORT_S : PORT_L;
  end
endmodule

// File: rtl/route_compute.sv
// route_compute: XY route for head flits, route locked until tail, one registered
// valid/ready stage towards the switch allocator.
module route_compute
  import noc_pkg::*;
#(
  parameter int FLIT_W  = FLIT_W_DEF,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        my_addr_i,
  input  logic [FLIT_W-1:0] in_flit_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [FLIT_W-1:0] out_flit_o,
  output logic [4:0]        out_port_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              err_o
);
  state_e     state;
  flit_type_e ftype;
  logic [4:0] route, route_q;
  logic       acc, ok;
  xy_route #(.COORD_W(COORD_W)) u_xy (.dest(in_flit_i[7:0]), .my_addr(my_addr_i), .port(route));
  assign in_ready_o = !out_valid_o || out_ready_i;
  assign acc = in_valid_i && in_ready_o;
  assign ftype = flit_type_e'(in_flit_i[FLIT_W-1 -: 2]);
  assign ok = state == IDLE ? (ftype == HEAD || ftype == SINGLE) : (ftype == BODY || ftype == TAIL);
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      route_q     <= '0;
      out_valid_o <= 1'b0;
      out_flit_o  <= '0;
      out_port_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      err_o <= acc && !ok;
      if (acc && ok) begin
        out_valid_o <= 1'b1;
        out_flit_o  <= in_flit_i;
        out_port_o  <= state == IDLE ? route : route_q;
        if (state == IDLE && ftype == HEAD) begin
          state   <= PKT;
          route_q <= route;
        end
        if (state == PKT && ftype == TAIL) state <= IDLE;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_route_compute.sv
// tb_route_compute: table vectors, hand-written stall/error/reset sequences, and
// randomized traffic against a packet-level reference model.
module tb_route_compute;
  localparam int FW = 34;
  logic          clk = 0;
  logic          rst;
  logic [7:0]    my_addr;
  logic [FW-1:0] in_flit;
  logic          in_valid, in_ready;
  logic [FW-1:0] out_flit;
  logic [4:0]    out_port;
  logic          out_valid, out_ready, err;
  int n_vec = 0;
  int n_err = 0;

  route_compute dut (
    .clk(clk), .rst(rst), .my_addr_i(my_addr), .in_flit_i(in_flit), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .out_flit_o(out_flit), .out_port_o(out_port), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] t;
    logic [7:0] d;
    logic [7:0] m;
    logic       v;
    logic [4:0] p;
    logic       e;
  } vec_t;
  vec_t tbl[21];

  task automatic chk(input string nm, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int pay, input logic [7:0] d);
    logic [23:0] p;
    p = 24'(pay);
    return {t, p, d};
  endfunction

  // Reference XY route from coordinates as plain integers.
  function automatic logic [4:0] xy(input logic [7:0] d, input logic [7:0] m);
    int dx, dy, mx, my;
    dx = int'(d[7:4]); dy = int'(d[3:0]); mx = int'(m[7:4]); my = int'(m[3:0]);
    if (dx > mx) return 5'b00100;
    if (dx < mx) return 5'b10000;
    if (dy > my) return 5'b00010;
    if (dy < my) return 5'b01000;
    return 5'b00001;
  endfunction

  logic [FW-1:0] f_head, f_body, f_tail;
  logic          m_valid, m_pkt, m_err, m_rdy, acc, r;
  logic [FW-1:0] m_flit;
  logic [4:0]    m_port, m_route;
  logic [1:0]    typ;
  logic [7:0]    d;
  logic [3:0]    nib[4] = '{4'h0, 4'h1, 4'h2, 4'hF};

  initial begin
    tbl[0]  = '{2'b11, 8'h31, 8'h11, 1'b1, 5'b00100, 1'b0};
    tbl[1]  = '{2'b11, 8'h01, 8'h11, 1'b1, 5'b10000, 1'b0};
    tbl[2]  = '{2'b11, 8'h10, 8'h11, 1'b1, 5'b01000, 1'b0};
    tbl[3]  = '{2'b11, 8'h11, 8'h11, 1'b1, 5'b00001, 1'b0};
    tbl[4]  = '{2'b11, 8'h03, 8'h11, 1'b1, 5'b10000, 1'b0};
    tbl[5]  = '{2'b01, 8'h13, 8'h11, 1'b1, 5'b00010, 1'b0};
    tbl[6]  = '{2'b00, 8'h55, 8'h11, 1'b1, 5'b00010, 1'b0};
    tbl[7]  = '{2'b00, 8'hAA, 8'h11, 1'b1, 5'b00010, 1'b0};
    tbl[8]  = '{2'b10, 8'h00, 8'h11, 1'b1, 5'b00010, 1'b0};
    tbl[9]  = '{2'b00, 8'h31, 8'h11, 1'b0, 5'b00000, 1'b1};
    tbl[10] = '{2'b10, 8'h31, 8'h11, 1'b0, 5'b00000, 1'b1};
    tbl[11] = '{2'b01, 8'h31, 8'h11, 1'b1, 5'b00100, 1'b0};
    tbl[12] = '{2'b11, 8'h01, 8'h11, 1'b0, 5'b00000, 1'b1};
    tbl[13] = '{2'b01, 8'h01, 8'h11, 1'b0, 5'b00000, 1'b1};
    tbl[14] = '{2'b00, 8'h00, 8'h44, 1'b1, 5'b00100, 1'b0};
    tbl[15] = '{2'b10, 8'h00, 8'h44, 1'b1, 5'b00100, 1'b0};
    tbl[16] = '{2'b11, 8'h43, 8'h44, 1'b1, 5'b01000, 1'b0};
    tbl[17] = '{2'b11, 8'hF0, 8'h0F, 1'b1, 5'b00100, 1'b0};
    tbl[18] = '{2'b11, 8'h0F, 8'hF0, 1'b1, 5'b10000, 1'b0};
    tbl[19] = '{2'b11, 8'hFF, 8'hFF, 1'b1, 5'b00001, 1'b0};
    tbl[20] = '{2'b11, 8'h00, 8'h00, 1'b1, 5'b00001, 1'b0};

    rst = 1; my_addr = 8'h11; in_flit = '0; in_valid = 0; out_ready = 1;
    step(); step();
    chk("rst_out_valid", FW'(out_valid), '0);
    chk("rst_out_flit", out_flit, '0);
    chk("rst_out_port", FW'(out_port), '0);
    chk("rst_err", FW'(err), '0);
    rst = 0;
    step();
    chk("rst_in_ready", FW'(in_ready), 1);

    for (int i = 0; i < 21; i++) begin
      in_valid = 1; my_addr = tbl[i].m; in_flit = mk(tbl[i].t, i * 7 + 1, tbl[i].d);
      step();
      chk($sformatf("tbl%0d_valid", i), FW'(out_valid), FW'(tbl[i].v));
      chk($sformatf("tbl%0d_err", i), FW'(err), FW'(tbl[i].e));
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_port", i), FW'(out_port), FW'(tbl[i].p));
        chk($sformatf("tbl%0d_flit", i), out_flit, mk(tbl[i].t, i * 7 + 1, tbl[i].d));
      end
    end

    in_valid = 0; my_addr = 8'h11;
    step();
    chk("drain_idle_valid", FW'(out_valid), 0);
    f_head = mk(2'b01, 'h111, 8'h13); f_body = mk(2'b00, 'h222, 8'h99); f_tail = mk(2'b10, 'h333, 8'h77);
    out_ready = 0; in_valid = 1; in_flit = f_head;
    step();
    chk("bp_head_valid", FW'(out_valid), 1);
    in_flit = f_body;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("bp_stall%0d_in_ready", k), FW'(in_ready), 0);
      chk($sformatf("bp_stall%0d_flit", k), out_flit, f_head);
      chk($sformatf("bp_stall%0d_port", k), FW'(out_port), FW'(5'b00010));
    end
    out_ready = 1;
    #1 chk("bp_release_in_ready", FW'(in_ready), 1);
    step();
    chk("bp_body_flit", out_flit, f_body);
    chk("bp_body_port", FW'(out_port), FW'(5'b00010));
    in_flit = f_tail;
    step();
    chk("bp_tail_flit", out_flit, f_tail);
    chk("bp_tail_port", FW'(out_port), FW'(5'b00010));
    in_valid = 0;
    step();
    chk("bp_drain_valid", FW'(out_valid), 0);
    in_valid = 1; in_flit = mk(2'b11, 5, 8'h01);
    step();
    chk("bp_after_idle_port", FW'(out_port), FW'(5'b10000));

    in_flit = mk(2'b01, 6, 8'h31);
    step();
    in_valid = 0; rst = 1;
    step();
    chk("mid_rst_valid", FW'(out_valid), 0);
    chk("mid_rst_port", FW'(out_port), 0);
    rst = 0; in_valid = 1; in_flit = mk(2'b00, 7, 8'h00);
    step();
    chk("mid_rst_body_err", FW'(err), 1);
    chk("mid_rst_body_valid", FW'(out_valid), 0);
    in_valid = 0;
    step();
    chk("err_pulse_end", FW'(err), 0);

    rst = 1; step(); rst = 0;
    m_valid = 0; m_pkt = 0; m_route = '0; m_flit = '0; m_port = '0; m_err = 0;
    for (int c = 0; c < 3000; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      typ = 2'($urandom_range(0, 3));
      d = {nib[$urandom_range(0, 3)], nib[$urandom_range(0, 3)]};
      if ($urandom_range(0, 15) == 0) my_addr = {nib[$urandom_range(0, 3)], nib[$urandom_range(0, 3)]};
      r = $urandom_range(0, 99) == 0;
      rst = r;
      in_flit = mk(typ, c, d);
      #1;
      if (!r) chk("rnd_in_ready", FW'(in_ready), FW'(!m_valid || out_ready));
      if (r) begin
        m_valid = 0; m_pkt = 0; m_route = '0; m_err = 0;
      end else begin
        m_rdy = !m_valid || out_ready;
        acc = in_valid && m_rdy;
        if (m_valid && out_ready) m_valid = 0;
        m_err = 0;
        if (acc) begin
          if (!m_pkt && (typ == 2'b01 || typ == 2'b11)) begin
            m_valid = 1; m_flit = in_flit; m_port = xy(d, my_addr);
            if (typ == 2'b01) begin m_pkt = 1; m_route = m_port; end
          end else if (m_pkt && (typ == 2'b00 || typ == 2'b10)) begin
            m_valid = 1; m_flit = in_flit; m_port = m_route;
            if (typ == 2'b10) m_pkt = 0;
          end else m_err = 1;
        end
      end
      step();
      chk("rnd_valid", FW'(out_valid), FW'(m_valid));
      chk("rnd_err", FW'(err), FW'(m_err));
      if (m_valid) begin
        chk("rnd_flit", out_flit, m_flit);
        chk("rnd_port", FW'(out_port), FW'(m_port));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/route_compute.md
# route_compute

Route-computation stage of the router input port. It consumes flits from the input buffer and the router's own 8-bit address from the address flip-flop. It computes a dimension-ordered (XY) output port for each packet's head flit and locks that port until the tail flit passes. It presents each flit with its one-hot port request to the switch allocator through a single registered valid/ready stage.

## Interface
Parameters:
- FLIT_W, 34, flit width: bits [FLIT_W-1:FLIT_W-2] are the flit type, bits [7:0] are the head destination address.
- COORD_W, 4, width of each coordinate. The address is {x[7:4], y[3:0]}; 2*COORD_W must equal 8.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- my_addr_i  in  8  own address {x,y}; the reset value is 8'h11
- in_flit_i  in  FLIT_W  flit from the input buffer
- in_valid_i  in  1  in_flit_i is valid
- in_ready_o  out  1  this stage accepts the flit this cycle
- out_flit_o  out  FLIT_W  registered flit
- out_port_o  out  5  one-hot port request: bit0 LOCAL, 1 NORTH, 2 EAST, 3 SOUTH, 4 WEST
- out_valid_o  out  1  output register holds a flit
- out_ready_i  in  1  the allocator takes the flit this cycle
- err_o  out  1  one-cycle pulse when a protocol violation causes a drop

## Operation
- Flit types: 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 SINGLE (head and tail in one flit).
- A transfer occurs on the input when in_valid_i && in_ready_o, and on the output when out_valid_o && out_ready_i.
- in_ready_o = !out_valid_o || out_ready_i. This is combinational from out_ready_i; there is no path from in_valid_i.
- FSM states are IDLE and PKT.
  - IDLE + HEAD accepted: compute the route, load the output register, latch the route into route_q, go to PKT.
  - IDLE + SINGLE accepted: compute the route and load the output register. Stay in IDLE.
  - IDLE + BODY/TAIL accepted: drop the flit (output register not loaded), pulse err_o.
  - PKT + BODY accepted: load the output register with port = route_q.
  - PKT + TAIL accepted: load the output register with port = route_q, go to IDLE.
  - PKT + HEAD/SINGLE accepted: drop the flit, pulse err_o, stay in PKT.
- XY route. dx = dest[7:4], dy = dest[3:0], mx = my_addr_i[7:4], my = my_addr_i[3:0]. All comparisons are unsigned.
  - dx > mx → EAST; dx < mx → WEST.
  - Otherwise dy > my → NORTH; dy < my → SOUTH.
  - Otherwise → LOCAL.
- my_addr_i is sampled only in the cycle a head is accepted. Changes mid-packet do not affect route_q.
- out_port_o is always one-hot while out_valid_o = 1.
- Dropped flits still consume the input transfer, so in_ready_o governs them the same way.

## Timing
- Reset values:
  - out_valid_o = 0, out_flit_o = 0, out_port_o = 0, err_o = 0.
  - FSM = IDLE, route_q = 0.
  - in_ready_o = 1 one cycle after reset, because the output register is empty.
- Latency: a flit accepted at edge N appears on out_* after edge N. It is back-to-back capable: one flit per cycle while out_ready_i = 1.
- Stall: while out_valid_o && !out_ready_i, out_flit_o and out_port_o hold stable, in_ready_o = 0, and the FSM holds.
- Simultaneous drain and accept: the output register reloads in the same edge and out_valid_o stays 1.
- Drain with no accept: out_valid_o falls to 0 at the next edge.
- err_o is registered and is high exactly one cycle after the offending accept.
- rst asserted mid-packet clears the FSM, route_q and the output register at the next edge; any in-flight flit is discarded.

## Structure
- Shared package noc_pkg holds:
  - flit_type_e (HEAD/BODY/TAIL/SINGLE);
  - the port index constants and one-hot localparams (PORT_L/N/E/S/W);
  - state_e (IDLE/PKT);
  - FLIT_W and COORD_W defaults.
- One sub-module: xy_route, purely combinational. It takes (dest[7:0], my_addr[7:0]) and returns a 5-bit one-hot port. The FSM and the output register live in route_compute.

## Test plan
- my_addr 8'h11, SINGLE with dest 8'h31 → one cycle later out_port 5'b00100 (EAST), out_valid 1; FSM stays IDLE.
- my_addr 8'h11, HEAD dest 8'h13, BODY, BODY, TAIL back-to-back with out_ready 1 → four outputs on consecutive cycles, all port 5'b00010 (NORTH); FSM returns to IDLE after the TAIL.
- Route coverage: dest 8'h01 → WEST, 8'h10 → SOUTH, 8'h11 → LOCAL, 8'h03 → WEST (X is resolved before Y).
- Backpressure: hold out_ready 0 for 3 cycles with flits pending → in_ready 0 and out_flit/out_port stable; on release, flits resume in order with no loss or duplication.
- Protocol errors:
  - BODY while IDLE → no out_valid, err_o pulses 1 cycle.
  - HEAD during PKT → dropped, err_o pulses, and the following TAIL still uses the original route.
- Reset mid-packet: HEAD dest 8'h31 accepted, rst for one cycle → out_valid 0, FSM IDLE; a subsequent BODY raises err_o.
